// File: rtl/booth_mult_seq.sv
// booth_mult_seq: sequential radix-2 Booth multiplier for signed 8-bit operands.
// It performs one Booth iteration per clock, reusing a single 8-bit add/subtract
// unit (rcas8), and produces a 16-bit signed product {ACC,Q}.
// There is a start/done handshake: start is accepted in IDLE or DONE, and done
// pulses for one cycle when the product is valid.
// Optional feature macro: BOOTH_ZERO_SKIP_EN. When it is defined, a zero operand
// completes in one cycle without iterating.

// rcas8: 8-bit ripple-carry add/subtract unit.
// mode=0 gives A1+A2; mode=1 gives A1-A2. C is the carry out of bit 7.
module rcas8 (
    input  logic [7:0] A1,
    input  logic [7:0] A2,
    input  logic       mode,
    output logic [7:0] S,
    output logic       C
);
    logic [7:0] b;
    logic [8:0] cy;

    // Ripple-carry chain; subtraction inverts A2 and injects mode as carry-in
    always_comb begin
        b     = A2 ^ {8{mode}};
        cy    = '0;
        cy[0] = mode;
        S     = '0;
        for (int i = 0; i < 8; i++) begin
            S[i]    = A1[i] ^ b[i] ^ cy[i];
            cy[i+1] = (A1[i] & b[i]) | (cy[i] & (A1[i] ^ b[i]));
        end
        C = cy[8];
    end
endmodule

module booth_mult_seq #(
    parameter int WIDTH = 8,   // operand width; must match rcas8 (8 only)
    parameter int CNT_W = 4    // iteration counter width, 2**CNT_W > WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic signed [WIDTH-1:0]   mcand,
    input  logic signed [WIDTH-1:0]   mplier,
    output logic                      busy,
    output logic                      done,
    output logic signed [2*WIDTH-1:0] product
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                  state, state_nxt;
    logic signed [WIDTH-1:0] acc, q, m;
    logic                    q_1;
    logic [CNT_W-1:0]        count;

    logic                    accept;
    logic                    skip;
    logic                    do_op;
    logic                    mode;
    logic [WIDTH-1:0]        add_s;
    logic                    add_c;
    logic [WIDTH-1:0]        res;
    logic                    sb;

    // Sign bit shifted into ACC: this is the 9th bit of the true sum, so a
    // result that overflows 8 bits (for example ACC - (-128)) keeps its sign.
    function automatic logic shift_sign(input logic acc_msb, input logic m_msb,
                                        input logic sub, input logic carry,
                                        input logic op);
        return op ? (acc_msb ^ (m_msb ^ sub) ^ carry) : acc_msb;
    endfunction

`ifdef BOOTH_ZERO_SKIP_EN
    assign skip = (mcand == '0) || (mplier == '0);
`else
    assign skip = 1'b0;
`endif

    // Booth decode of {Q[0],q_1}: 01 adds M, 10 subtracts M, 00/11 pass ACC
    always_comb begin
        do_op = 1'b0;
        mode  = 1'b0;
        if (state == S_RUN) begin
            do_op = q[0] ^ q_1;
            mode  = q[0] & ~q_1;
        end
    end

    rcas8 u_addsub (
        .A1   (acc),
        .A2   (m),
        .mode (mode),
        .S    (add_s),
        .C    (add_c)
    );

    assign res     = do_op ? add_s : acc;
    assign sb      = shift_sign(acc[WIDTH-1], m[WIDTH-1], mode, add_c, do_op);
    assign product = {acc, q};

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic and handshake outputs
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = skip ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (count == CNT_W'(1)) state_nxt = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = skip ? S_DONE : S_RUN;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: load the operands on accept, then do one shift/add step per RUN cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc   <= '0;
            q     <= '0;
            m     <= '0;
            q_1   <= 1'b0;
            count <= '0;
        end else if (accept) begin
            m     <= mcand;
            q     <= skip ? '0 : mplier;
            acc   <= '0;
            q_1   <= 1'b0;
            count <= skip ? '0 : CNT_W'(WIDTH);
        end else if (state == S_RUN) begin
            acc   <= {sb, res[WIDTH-1:1]};
            q     <= {res[0], q[WIDTH-1:1]};
            q_1   <= q[0];
            count <= count - CNT_W'(1);
        end
    end
endmodule

// File: doc/booth_mult_seq.md
Name: booth_mult_seq

Overview:
- Sequential radix-2 Booth multiplier for signed 8-bit operands; produces a 16-bit signed product.
- Controller, state machine and shift registers wrapped around one 8-bit add/subtract unit: the existing RCAS8 (A1, A2, mode, S, C; mode=0 add, mode=1 subtract).
- Performs one Booth iteration per clock, reusing the single adder every cycle.
- Sits in the boothMult datapath as the top-level multiply engine, driven by a simple start/done handshake.

Parameters:
- WIDTH, 8, operand width.
  - Must equal the add/sub unit width; only 8 is supported.
- CNT_W, 4, iteration counter width.
  - Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request.
  - Sampled only in IDLE or DONE.
- mcand  input  8  signed multiplicand M.
  - Sampled on the edge where start is accepted.
- mplier  input  8  signed multiplier Q.
  - Sampled on the edge where start is accepted.
- busy  output  1  high while iterating (LOAD/RUN).
- done  output  1  one-cycle pulse: product valid.
- product  output  16  signed product {ACC,Q}.
  - Held stable until the next accepted start.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; ACC, Q, M, q_1, count cleared.
  - busy=0, done=0, product=0.
  - Applies immediately, including mid-operation; the in-flight multiply is discarded.
- States: IDLE, RUN, DONE.
- IDLE/DONE with start=1 at edge E0:
  - M<=mcand, Q<=mplier, ACC<=0, q_1<=0, count<=WIDTH.
  - state<=RUN.
- IDLE/DONE with start=0:
  - IDLE stays IDLE; DONE goes to IDLE.
  - Registers hold.
- RUN, each edge:
  - Inspect {Q[0],q_1}:
    - 01: adder computes ACC+M (mode=0).
    - 10: adder computes ACC-M (mode=1).
    - 00/11: pass; S=ACC, adder result ignored.
  - Arithmetic right shift: {ACC,Q,q_1} <= {sb, R, Q}, where R is S or ACC (pass).
  - count<=count-1.
  - When count reaches 1, the next edge moves state to DONE.
- Shift-in sign bit sb (9th bit of the true sum; prevents overflow corruption):
  - Add/sub: sb = ACC[7] ^ (M[7]^mode) ^ C.
  - Pass: sb = ACC[7].
- Latency:
  - start accepted at E0; iterations at E1..E8; state=DONE after E8.
  - done=1 for exactly the cycle after E8, then 0.
- busy:
  - 1 from after E0 through E8.
  - 0 in IDLE and DONE.
- start while busy=1: ignored; operands unchanged, no effect.
- Back-to-back: start=1 during the DONE cycle is accepted.
  - That edge acts as E0 of the next operation; done drops.
- product:
  - Combinational view of {ACC,Q}, but only guaranteed meaningful from DONE until the next E0.
  - Holds its value in IDLE.
- Boundaries, all exact in 16 bits:
  - M=-128 subtract handled via sb; -128*-128 = 0x4000.
  - Multiplier -128 handled the same way.
- Adder mode is 0 in IDLE/DONE.

Optional Feature:
- Macro: BOOTH_ZERO_SKIP_EN.
- Defined: if mcand==0 or mplier==0 when start is accepted:
  - Registers load with ACC=0, Q=0; state goes directly to DONE.
  - done pulses in the cycle after E0 (latency 1).
  - busy stays 0; product=0.
- Undefined: zero operands take the full WIDTH iterations like any other; product=0.

Test Plan:
- After reset, start with mcand=3, mplier=2 -> busy high 8 cycles; done pulse exactly 9 cycles after the start edge; product=0x0006.
- mcand=5, mplier=3, then mcand=-7 (0xF9), mplier=6 back-to-back (start held during DONE) -> product 0x000F, then 0xFFD6; no idle cycle between operations.
- mcand=-128, mplier=-128 -> 0x4000; mcand=127, mplier=-128 -> 0xC080; mcand=-128, mplier=127 -> 0xC080.
- Start during RUN with new operands 0x11/0x22 -> ignored; original result 0x0006 delivered at the original done time.
- Assert rst=0 at the 4th RUN cycle:
  - Immediately: busy=0, product=0, no done pulse.
  - Then start mcand=10, mplier=-10 -> 0xFF9C.
- mcand=0, mplier=0x55:
  - With BOOTH_ZERO_SKIP_EN: done 1 cycle after start, busy never high.
  - Without: done after 9 cycles.
  - Both: product=0.
